// File: rtl/dla_pkg.sv
// Shared definitions for the 2x2 pooling feeder: state encoding, pixel type, size defaults.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package dla_pkg;

  localparam int DATA_WID_DEF = 16;
  localparam int MAX_COLS_DEF = 64;
  localparam int COL_WID_DEF  = 7;

  typedef logic signed [DATA_WID_DEF-1:0] pixel_t;

  // One-hot feeder states
  typedef enum logic [3:0] {
    ST_IDLE  = 4'b0001,
    ST_TOP   = 4'b0010,
    ST_BOT   = 4'b0100,
    ST_FLUSH = 4'b1000
  } state_t;

endpackage

// File: rtl/dla_line_buf.sv
// One-row pixel store for the pooling feeder: register array, one write port, one async read port.
// Latency: write lands at the clock edge; read is combinational from rd_addr.
// Backpressure: none; the caller owns all flow control.
// Ports: clock; wr_en/wr_addr/wr_data write port; rd_addr -> rd_data read port. Storage is not reset.
module dla_line_buf #(
  parameter int DATA_WID = 16,
  parameter int DEPTH    = 64,
  parameter int ADDR_WID = 6
) (
  input  logic                clock,
  input  logic                wr_en,
  input  logic [ADDR_WID-1:0] wr_addr,
  input  logic [DATA_WID-1:0] wr_data,
  input  logic [ADDR_WID-1:0] rd_addr,
  output logic [DATA_WID-1:0] rd_data
);

  logic [DATA_WID-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/dla_pool_feeder.sv
// Turns a raster pixel stream into non-overlapping 2x2 stride-2 windows for the pooling unit.
// Latency: window appears (win_en) one cycle after the bottom-right pixel transfer.
// Backpressure: in_ready low while idle/flushing and on odd bottom-row columns until WIN_GAP has elapsed.
// Ports: clock, rst (sync, active-high); cfg_start/cfg_cols/cfg_rows plane setup;
//        in_valid/in_data/in_ready pixel stream; win_en + dat_0..dat_3 window out;
//        busy, done, cfg_err status.
module dla_pool_feeder
  import dla_pkg::*;
#(
  parameter int DATA_WID = DATA_WID_DEF,
  parameter int MAX_COLS = MAX_COLS_DEF,
  parameter int COL_WID  = COL_WID_DEF,
  parameter int WIN_GAP  = 3
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic                       cfg_start,
  input  logic [COL_WID-1:0]         cfg_cols,
  input  logic [COL_WID-1:0]         cfg_rows,
  input  logic                       in_valid,
  input  logic signed [DATA_WID-1:0] in_data,
  output logic                       in_ready,
  output logic                       win_en,
  output logic signed [DATA_WID-1:0] dat_0,
  output logic signed [DATA_WID-1:0] dat_1,
  output logic signed [DATA_WID-1:0] dat_2,
  output logic signed [DATA_WID-1:0] dat_3,
  output logic                       busy,
  output logic                       done,
  output logic                       cfg_err
);

  localparam int LB_AW   = (MAX_COLS > 1) ? $clog2(MAX_COLS) : 1;
  localparam int GAP_WID = (WIN_GAP > 1) ? $clog2(WIN_GAP) : 1;
  localparam logic [GAP_WID-1:0] GAP_LOAD  = GAP_WID'(WIN_GAP - 1);
  localparam logic [COL_WID-1:0] MAX_C     = COL_WID'(MAX_COLS);
  localparam logic [COL_WID-1:0] MIN_DIM   = COL_WID'(2);

  state_t state, state_nxt;

  logic [COL_WID-1:0] cols_r, rows_r, col, row;
  logic [COL_WID-1:0] ecols, erows;
  logic [GAP_WID-1:0] gap_cnt;
  logic signed [DATA_WID-1:0] hold_tl, hold_bl;
  logic [DATA_WID-1:0] lb_rdata;

  logic acc, col_last, drop_row, rows_left, gap_zero, cfg_bad, lb_we, in_win;

  // Odd trailing column/row are consumed but never form a window
  assign ecols     = {cols_r[COL_WID-1:1], 1'b0};
  assign erows     = {rows_r[COL_WID-1:1], 1'b0};
  assign col_last  = (col == cols_r - 1'b1);
  assign drop_row  = (row >= erows);
  assign rows_left = ((row + 1'b1) < rows_r);
  assign gap_zero  = (gap_cnt == '0);
  assign in_win    = (col < ecols);
  assign cfg_bad   = (cfg_cols < MIN_DIM) || (cfg_rows < MIN_DIM) || (cfg_cols > MAX_C);

  // Even bottom-row columns only latch, so they may proceed during the gap;
  // odd ones emit a window and must wait for the spacing counter.
  assign in_ready = (state == ST_TOP) ||
                    ((state == ST_BOT) && (gap_zero || !col[0]));
  assign acc      = in_valid && in_ready;
  assign lb_we    = (state == ST_TOP) && acc && in_win && !drop_row;

  dla_line_buf #(
    .DATA_WID (DATA_WID),
    .DEPTH    (MAX_COLS),
    .ADDR_WID (LB_AW)
  ) u_line_buf (
    .clock   (clock),
    .wr_en   (lb_we),
    .wr_addr (col[LB_AW-1:0]),
    .wr_data (in_data),
    .rd_addr (col[LB_AW-1:0]),
    .rd_data (lb_rdata)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE:  if (cfg_start && !cfg_bad) state_nxt = ST_TOP;
      ST_TOP:   if (acc && col_last) state_nxt = drop_row ? ST_FLUSH : ST_BOT;
      ST_BOT:   if (acc && col_last) state_nxt = rows_left ? ST_TOP : ST_FLUSH;
      ST_FLUSH: if (gap_zero) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state   <= ST_IDLE;
      cols_r  <= '0;
      rows_r  <= '0;
      col     <= '0;
      row     <= '0;
      gap_cnt <= '0;
      hold_tl <= '0;
      hold_bl <= '0;
      win_en  <= 1'b0;
      dat_0   <= '0;
      dat_1   <= '0;
      dat_2   <= '0;
      dat_3   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      cfg_err <= 1'b0;
    end else begin
      state  <= state_nxt;
      win_en <= 1'b0;
      done   <= 1'b0;
      if (!gap_zero) gap_cnt <= gap_cnt - 1'b1;

      case (state)
        ST_IDLE: begin
          if (cfg_start) begin
            cfg_err <= cfg_bad;
            cols_r  <= cfg_cols;
            rows_r  <= cfg_rows;
            col     <= '0;
            row     <= '0;
            // A rejected config still reports completion so the caller never stalls
            if (cfg_bad) done <= 1'b1;
            else         busy <= 1'b1;
          end
        end
        ST_TOP, ST_BOT: begin
          if (acc) begin
            if (col_last) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if ((state == ST_BOT) && in_win) begin
              if (!col[0]) begin
                hold_bl <= in_data;
                hold_tl <= lb_rdata;
              end else begin
                dat_0   <= hold_tl;
                dat_1   <= lb_rdata;
                dat_2   <= hold_bl;
                dat_3   <= in_data;
                win_en  <= 1'b1;
                gap_cnt <= GAP_LOAD;
              end
            end
          end
        end
        ST_FLUSH: begin
          // Holding done back until the gap expires keeps it clear of the last win_en
          if (gap_zero) begin
            done <= 1'b1;
            busy <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dla_pool_feeder.sv
module tb_dla_pool_feeder;
  import dla_pkg::*;

  localparam int CW = 7;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst, cfg_start, in_valid, sel;
  logic [CW-1:0] cfg_cols, cfg_rows;
  pixel_t        in_data;

  logic   rdy_a, win_a, busy_a, done_a, err_a;
  logic   rdy_b, win_b, busy_b, done_b, err_b;
  pixel_t d0_a, d1_a, d2_a, d3_a, d0_b, d1_b, d2_b, d3_b;

  // Instance a: WIN_GAP=3, instance b: WIN_GAP=5; sel steers stimulus and observation
  dla_pool_feeder #(.WIN_GAP(3)) u_dut (
    .clock(clock), .rst(rst), .cfg_start(cfg_start & ~sel),
    .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .in_valid(in_valid & ~sel), .in_data(in_data), .in_ready(rdy_a),
    .win_en(win_a), .dat_0(d0_a), .dat_1(d1_a), .dat_2(d2_a), .dat_3(d3_a),
    .busy(busy_a), .done(done_a), .cfg_err(err_a)
  );

  dla_pool_feeder #(.WIN_GAP(5)) u_dut5 (
    .clock(clock), .rst(rst), .cfg_start(cfg_start & sel),
    .cfg_cols(cfg_cols), .cfg_rows(cfg_rows),
    .in_valid(in_valid & sel), .in_data(in_data), .in_ready(rdy_b),
    .win_en(win_b), .dat_0(d0_b), .dat_1(d1_b), .dat_2(d2_b), .dat_3(d3_b),
    .busy(busy_b), .done(done_b), .cfg_err(err_b)
  );

  logic        in_ready, win_en, busy, done, cfg_err;
  logic [63:0] win_dat;
  assign in_ready = sel ? rdy_b  : rdy_a;
  assign win_en   = sel ? win_b  : win_a;
  assign busy     = sel ? busy_b : busy_a;
  assign done     = sel ? done_b : done_a;
  assign cfg_err  = sel ? err_b  : err_a;
  assign win_dat  = sel ? {d0_b, d1_b, d2_b, d3_b} : {d0_a, d1_a, d2_a, d3_a};

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  int last_win = 0;
  int n_win = 0, n_done = 0, n_acc = 0, gap_req = 3;
  pixel_t pix [256];
  logic [63:0] wq [$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  always @(posedge clock) cyc <= cyc + 1;

  // Observation at the falling edge: transfers, windows, done pulses
  always @(negedge clock) begin
    if (!rst) begin
      if (in_valid && in_ready) n_acc++;
      if (win_en) begin
        n_win++;
        if (n_win > 1) chk("win_spacing", 64'((cyc - last_win) >= gap_req), 64'd1);
        last_win = cyc;
        chk("win_expected", 64'(wq.size() != 0), 64'd1);
        if (wq.size() != 0) chk("win_data", win_dat, wq.pop_front());
      end
      if (done) begin
        n_done++;
        chk("done_no_win", win_en, 1'b0);
        chk("busy_at_done", busy, 1'b0);
      end
    end
  end

  task automatic start_plane(input int cols, input int rows);
    int ec = cols & ~1;
    int er = rows & ~1;
    for (int r = 0; r < er; r += 2)
      for (int c = 0; c < ec; c += 2)
        wq.push_back({pix[r*cols+c], pix[r*cols+c+1], pix[(r+1)*cols+c], pix[(r+1)*cols+c+1]});
    n_win = 0; n_done = 0; n_acc = 0;
    cfg_cols  = CW'(cols);
    cfg_rows  = CW'(rows);
    cfg_start = 1'b1;
    @(posedge clock); #1;
    cfg_start = 1'b0;
    chk("busy_after_start", busy, 1'b1);
    chk("cfg_err_clear", cfg_err, 1'b0);
  endtask

  task automatic feed(input int n, input int gap_pct);
    int p = 0;
    int budget = 0;
    logic hs;
    while (p < n && budget < 4000) begin
      in_valid = ($urandom_range(99) >= gap_pct);
      in_data  = pix[p];
      @(negedge clock);
      hs = in_valid && in_ready;
      @(posedge clock); #1;
      if (hs) p++;
      budget++;
    end
    in_valid = 1'b0;
    chk("pixels_fed", 64'(p), 64'(n));
  endtask

  task automatic finish_plane(input int cols, input int rows);
    int k = 0;
    while (n_done == 0 && k < 300) begin
      @(posedge clock); #1;
      k++;
    end
    repeat (3) begin @(posedge clock); #1; end
    chk("done_count", 64'(n_done), 64'd1);
    chk("windows_left", 64'(wq.size()), 64'd0);
    chk("window_count", 64'(n_win), 64'((cols/2)*(rows/2)));
    chk("pixels_consumed", 64'(n_acc), 64'(cols*rows));
    chk("ready_after_done", in_ready, 1'b0);
    chk("busy_after_done", busy, 1'b0);
  endtask

  task automatic bad_cfg(input int cols, input int rows);
    n_win = 0; n_done = 0; n_acc = 0;
    cfg_cols  = CW'(cols);
    cfg_rows  = CW'(rows);
    cfg_start = 1'b1;
    in_valid  = 1'b1;
    @(posedge clock); #1;
    cfg_start = 1'b0;
    chk("err_set", cfg_err, 1'b1);
    chk("err_done_pulse", done, 1'b1);
    chk("err_not_busy", busy, 1'b0);
    chk("err_ready", in_ready, 1'b0);
    repeat (4) begin @(posedge clock); #1; end
    chk("err_sticky", cfg_err, 1'b1);
    chk("err_done_once", 64'(n_done), 64'd1);
    chk("err_no_win", 64'(n_win), 64'd0);
    chk("err_no_pixels", 64'(n_acc), 64'd0);
    in_valid = 1'b0;
  endtask

  task automatic check_idle_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1'b0);
    chk({tag, "_win_en"}, win_en, 1'b0);
    chk({tag, "_dat"}, win_dat, 64'd0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_cfg_err"}, cfg_err, 1'b0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 1'b0; rst = 1'b1; cfg_start = 1'b0; cfg_cols = '0; cfg_rows = '0;
    in_valid = 1'b0; in_data = '0;
    repeat (3) @(posedge clock);
    #1;
    check_idle_zero("reset");
    rst = 1'b0;
    @(posedge clock); #1;

    // 4x4 sequential plane
    for (int i = 0; i < 256; i++) pix[i] = pixel_t'(i);
    start_plane(4, 4); feed(16, 0); finish_plane(4, 4);

    // 5x3 plane: last column and last row dropped
    start_plane(5, 3); feed(15, 0); finish_plane(5, 3);

    // Signed extremes 4x2
    pix[0] = -16'sd32768; pix[1] = 16'sd32767; pix[2] = -16'sd1; pix[3] = 16'sd0;
    pix[4] = 16'sd1;      pix[5] = -16'sd2;    pix[6] = 16'sd32767; pix[7] = -16'sd32768;
    start_plane(4, 2); feed(8, 0); finish_plane(4, 2);

    // 8x8 without gaps on WIN_GAP=3, then with random gaps on WIN_GAP=5
    for (int i = 0; i < 256; i++) pix[i] = pixel_t'(i * 37 - 1000);
    start_plane(8, 8); feed(64, 0); finish_plane(8, 8);
    sel = 1'b1; gap_req = 5;
    @(posedge clock); #1;
    start_plane(8, 8); feed(64, 50); finish_plane(8, 8);
    sel = 1'b0; gap_req = 3;
    @(posedge clock); #1;

    // Illegal configurations, then a legal plane clears cfg_err
    bad_cfg(1, 4);
    bad_cfg(66, 4);
    for (int i = 0; i < 256; i++) pix[i] = pixel_t'(i);
    start_plane(4, 4); feed(16, 0); finish_plane(4, 4);

    // Reset in the middle of the second row
    start_plane(4, 4); feed(6, 0);
    rst = 1'b1;
    @(posedge clock); #1;
    check_idle_zero("abort");
    rst = 1'b0;
    wq.delete();
    n_done = 0;
    repeat (5) begin @(posedge clock); #1; end
    chk("abort_no_done", 64'(n_done), 64'd0);
    chk("abort_idle_ready", in_ready, 1'b0);
    start_plane(4, 4); feed(16, 0); finish_plane(4, 4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
